// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done operand and result bundle for serial_adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  s, cout, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output s, cout, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder reusing one full-adder cell, LSB first
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next, s_q;
    logic             carry, cout_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       bit_add;
    logic             accept, last;

    assign bit_add = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry};
    assign last    = (cnt == CW'(WIDTH - 1));

    // Newest sum bit enters at the MSB so the LSB-first result ends up in place.
    generate
        if (WIDTH == 1) begin : g_one_bit
            assign sum_next = bit_add[0];
        end else begin : g_multi_bit
            assign sum_next = {bit_add[0], sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                carry  <= bit_add[1];
                cnt    <= cnt + CW'(1);
                sum_sh <= sum_next;
                if (last) begin
                    s_q    <= sum_next;
                    cout_q <= bit_add[1];
                end
            end
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed checks of serial_adder against arithmetic reference
module tb_serial_adder;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;
    logic [7:0] exp_s8 = 8'h00;
    logic       exp_c8 = 1'b0;
    int   dones2 = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(2)) bus2 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One 8-bit operation; operands are scrambled and start pulsed while running.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input string tag);
        logic [8:0] ref_sum;
        int n, nb;
        ref_sum = 9'(a) + 9'(b) + 9'(ci);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = ci;
        @(negedge clk);
        bus8.start = 1'b0;
        n = 0; nb = 0;
        while (!bus8.done && n < 40) begin
            if (bus8.busy) nb++;
            check({tag, "_hold"}, 32'({bus8.cout, bus8.s}), 32'({exp_c8, exp_s8}));
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            bus8.start = (n == 3);
            @(negedge clk);
            n++;
        end
        bus8.start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
        check({tag, "_busy_in_done"}, 32'(bus8.busy), 32'd0);
        check({tag, "_sum"}, 32'({bus8.cout, bus8.s}), 32'(ref_sum));
        exp_s8 = ref_sum[7:0];
        exp_c8 = ref_sum[8];
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        logic [2:0] ref_sum;
        int n;
        ref_sum = 3'(a) + 3'(b) + 3'(ci);
        @(negedge clk);
        bus2.start = 1'b1; bus2.a = a; bus2.b = b; bus2.cin = ci;
        @(negedge clk);
        bus2.start = 1'b0;
        n = 0;
        while (!bus2.done && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus2.done) dones2++;
        check($sformatf("w2_sum_%0d_%0d_%0d", a, b, ci), 32'({bus2.cout, bus2.s}), 32'(ref_sum));
        check("w2_latency", 32'(n), 32'd2);
    endtask

    initial begin
        int n, d1, d2, gap, late_dones;
        reset = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s8", 32'({bus8.cout, bus8.s}), 32'd0);
        check("rst_busy8", 32'(bus8.busy), 32'd0);
        check("rst_done8", 32'(bus8.done), 32'd0);
        check("rst_s2", 32'({bus2.cout, bus2.s}), 32'd0);
        check("rst_flags2", 32'({bus2.busy, bus2.done}), 32'd0);
        reset = 1'b0;

        op8(8'h5A, 8'h33, 1'b0, "dir_5a_33");
        op8(8'hFF, 8'h01, 1'b0, "dir_ff_01");
        op8(8'hFF, 8'hFF, 1'b1, "dir_ff_ff_1");
        op8(8'h00, 8'h00, 1'b0, "dir_zero");
        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));

        // Back-to-back accepts with start held high.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd1; bus8.b = 8'd2; bus8.cin = 1'b0;
        @(negedge clk);
        bus8.a = 8'd3; bus8.b = 8'd4;
        n = 0; d1 = -1; d2 = -1; gap = 0;
        while (d2 < 0 && n < 60) begin
            if (bus8.done) begin
                if (d1 < 0) begin
                    d1 = n;
                    check("b2b_first_sum", 32'({bus8.cout, bus8.s}), 32'd3);
                end else begin
                    d2 = n;
                    check("b2b_second_sum", 32'({bus8.cout, bus8.s}), 32'd7);
                    bus8.start = 1'b0;
                end
            end
            if (!bus8.busy && !bus8.done) gap++;
            if (d2 < 0) begin
                @(negedge clk);
                n++;
            end
        end
        bus8.start = 1'b0;
        check("b2b_first_done", 32'(d1), 32'd8);
        check("b2b_second_done", 32'(d2), 32'd17);
        check("b2b_no_idle_gap", 32'(gap), 32'd0);
        @(negedge clk);
        check("b2b_idle_after", 32'({bus8.busy, bus8.done}), 32'd0);
        exp_s8 = 8'd7; exp_c8 = 1'b0;

        // Reset in the middle of a run.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h7E; bus8.cin = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_before_rst", 32'(bus8.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus8.busy), 32'd0);
        check("mid_rst_done", 32'(bus8.done), 32'd0);
        check("mid_rst_result", 32'({bus8.cout, bus8.s}), 32'd0);
        late_dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) late_dones++;
        end
        check("mid_rst_no_done", 32'(late_dones), 32'd0);
        exp_s8 = 8'h00; exp_c8 = 1'b0;
        op8(8'h80, 8'h80, 1'b0, "after_rst");

        for (int i = 0; i < 32; i++)
            op2(2'(i >> 3), 2'(i >> 1), 1'(i));
        check("w2_done_count", 32'(dones2), 32'd32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
